// File: rtl/dds_wavegen_if.sv
// ---------------------------------------------------------------------------
// dds_wavegen_if
// Staged-configuration bus for dds_wavegen.
//   cfg_chan   : target channel of a staged write
//   cfg_freq   : frequency (phase increment) word
//   cfg_offset : phase offset; in DC mode its top bits are the output level
//   cfg_mode   : 0 ramp, 1 square, 2 triangle, 3 DC
//   cfg_valid  : staged-write request
//   cfg_ready  : write accepted when cfg_valid && cfg_ready
//   commit     : copy all staged registers to the active registers
// master drives the request side, slave (the generator) drives cfg_ready.
// ---------------------------------------------------------------------------
interface dds_wavegen_if #(
    parameter int unsigned PHASE_WIDTH = 32
);
    logic [3:0]             cfg_chan;
    logic [PHASE_WIDTH-1:0] cfg_freq;
    logic [PHASE_WIDTH-1:0] cfg_offset;
    logic [1:0]             cfg_mode;
    logic                   cfg_valid;
    logic                   cfg_ready;
    logic                   commit;

    modport master (
        output cfg_chan, cfg_freq, cfg_offset, cfg_mode, cfg_valid, commit,
        input  cfg_ready
    );

    modport slave (
        input  cfg_chan, cfg_freq, cfg_offset, cfg_mode, cfg_valid, commit,
        output cfg_ready
    );
endinterface

// File: rtl/dds_wavegen.sv
// ---------------------------------------------------------------------------
// dds_wavegen
// Multi-channel DDS waveform generator with double-buffered configuration.
// Each channel has a phase accumulator, staged and active freq/offset/mode
// registers; a commit copies all staged registers to the active set at once.
//
// Ports:
//   clk        : DAC sample clock
//   rst_n      : asynchronous active-low reset
//   cfg        : dds_wavegen_if.slave staged-write / commit bus
//   enable     : accumulators advance while high
//   phase_clr  : zero all accumulators (priority over enable)
//   dout       : samples, channel n at [n*DATA_WIDTH +: DATA_WIDTH]
//   dout_valid : dout holds a sample produced while enabled
//   wrap       : per-channel accumulator-overflow pulse, aligned with dout
//
// Optional feature macro: DDS_TRIANGLE_EN
//   defined   -> mode 2 produces a triangle wave
//   undefined -> mode 2 behaves exactly as ramp
//
// Pipeline: edge k updates acc, edge k+1 registers phase/mode,
// edge k+2 registers dout/wrap/dout_valid.
// ---------------------------------------------------------------------------
module dds_wavegen #(
    parameter int unsigned CHANNELS    = 2,
    parameter int unsigned PHASE_WIDTH = 32,
    parameter int unsigned DATA_WIDTH  = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    dds_wavegen_if.slave                   cfg,
    input  logic                           enable,
    input  logic                           phase_clr,
    output logic [CHANNELS*DATA_WIDTH-1:0] dout,
    output logic                           dout_valid,
    output logic [CHANNELS-1:0]            wrap
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_STAGED,
        S_APPLY
    } state_t;

    typedef enum logic [1:0] {
        MODE_RAMP   = 2'd0,
        MODE_SQUARE = 2'd1,
        MODE_TRI    = 2'd2,
        MODE_DC     = 2'd3
    } mode_t;

    // Phase bits kept after the add: the triangle needs one bit below the
    // ramp field, otherwise only the top DATA_WIDTH bits matter.
`ifdef DDS_TRIANGLE_EN
    localparam int unsigned PK = DATA_WIDTH + 1;
`else
    localparam int unsigned PK = DATA_WIDTH;
`endif

    // ---------------- configuration registers / control FSM --------------
    state_t                 state_q;
    logic                   cfg_ready_q;
    logic [PHASE_WIDTH-1:0] stg_freq_q [CHANNELS];
    logic [PHASE_WIDTH-1:0] stg_off_q  [CHANNELS];
    logic [1:0]             stg_mode_q [CHANNELS];
    logic [PHASE_WIDTH-1:0] act_freq_q [CHANNELS];
    logic [PHASE_WIDTH-1:0] act_off_q  [CHANNELS];
    logic [1:0]             act_mode_q [CHANNELS];
    logic                   wr_acc;

    assign wr_acc        = cfg.cfg_valid && cfg_ready_q;
    assign cfg.cfg_ready = cfg_ready_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cfg_ready_q <= 1'b1;
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                stg_freq_q[c] <= '0;
                stg_off_q[c]  <= '0;
                stg_mode_q[c] <= '0;
                act_freq_q[c] <= '0;
                act_off_q[c]  <= '0;
                act_mode_q[c] <= '0;
            end
        end else begin
            // Out-of-range channel numbers match nothing and are dropped,
            // but the handshake still completes below.
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                if (wr_acc && cfg.cfg_chan == 4'(c)) begin
                    stg_freq_q[c] <= cfg.cfg_freq;
                    stg_off_q[c]  <= cfg.cfg_offset;
                    stg_mode_q[c] <= cfg.cfg_mode;
                end
            end
            unique case (state_q)
                S_IDLE: begin
                    if (wr_acc) state_q <= S_STAGED;
                end
                S_STAGED: begin
                    // A write in the commit cycle lands in the staged regs at
                    // this edge, so APPLY picks it up.
                    if (cfg.commit) begin
                        state_q     <= S_APPLY;
                        cfg_ready_q <= 1'b0;
                    end
                end
                S_APPLY: begin
                    for (int unsigned c = 0; c < CHANNELS; c++) begin
                        act_freq_q[c] <= stg_freq_q[c];
                        act_off_q[c]  <= stg_off_q[c];
                        act_mode_q[c] <= stg_mode_q[c];
                    end
                    state_q     <= S_IDLE;
                    cfg_ready_q <= 1'b1;
                end
                default: begin
                    state_q     <= S_IDLE;
                    cfg_ready_q <= 1'b1;
                end
            endcase
        end
    end

    // ---------------- accumulators ----------------------------------------
    logic [PHASE_WIDTH:0]   sum_w     [CHANNELS];
    logic [PHASE_WIDTH-1:0] acc_d     [CHANNELS];
    logic [PHASE_WIDTH-1:0] acc_q     [CHANNELS];
    logic [CHANNELS-1:0]    wrap_int_d;
    logic [CHANNELS-1:0]    wrap_int_q;
    logic                   en0_q;

    always_comb begin
        wrap_int_d = '0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            sum_w[c] = {1'b0, acc_q[c]} + {1'b0, act_freq_q[c]};
            acc_d[c] = acc_q[c];
            if (phase_clr) begin
                acc_d[c] = '0;
            end else if (enable) begin
                acc_d[c]      = sum_w[c][PHASE_WIDTH-1:0];
                wrap_int_d[c] = sum_w[c][PHASE_WIDTH];
            end
        end
    end

    // ---------------- phase / waveform pipeline ---------------------------
    logic [PK-1:0]          p1_q    [CHANNELS];
    logic [1:0]             mode1_q [CHANNELS];
    logic [DATA_WIDTH-1:0]  dc1_q   [CHANNELS];
    logic [CHANNELS-1:0]    wrap1_q;
    logic                   v1_q;
    logic [DATA_WIDTH-1:0]  wave_w  [CHANNELS];

    logic [CHANNELS*DATA_WIDTH-1:0] dout_q;
    logic [CHANNELS-1:0]            wrap_q;
    logic                           dout_valid_q;

    always_comb begin
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            wave_w[c] = p1_q[c][PK-1 -: DATA_WIDTH];
            case (mode1_q[c])
                MODE_SQUARE: wave_w[c] = {DATA_WIDTH{p1_q[c][PK-1]}};
`ifdef DDS_TRIANGLE_EN
                MODE_TRI:    wave_w[c] = p1_q[c][PK-1] ? ~p1_q[c][DATA_WIDTH-1:0]
                                                       :  p1_q[c][DATA_WIDTH-1:0];
`endif
                MODE_DC:     wave_w[c] = dc1_q[c];
                default:     ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                acc_q[c]   <= '0;
                p1_q[c]    <= '0;
                mode1_q[c] <= '0;
                dc1_q[c]   <= '0;
            end
            wrap_int_q   <= '0;
            en0_q        <= 1'b0;
            wrap1_q      <= '0;
            v1_q         <= 1'b0;
            dout_q       <= '0;
            wrap_q       <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                acc_q[c]   <= acc_d[c];
                p1_q[c]    <= PK'((acc_q[c] + act_off_q[c]) >> (PHASE_WIDTH - PK));
                mode1_q[c] <= act_mode_q[c];
                dc1_q[c]   <= act_off_q[c][PHASE_WIDTH-1 -: DATA_WIDTH];
                if (v1_q) dout_q[c*DATA_WIDTH +: DATA_WIDTH] <= wave_w[c];
            end
            wrap_int_q   <= wrap_int_d;
            en0_q        <= enable;
            wrap1_q      <= wrap_int_q;
            v1_q         <= en0_q;
            wrap_q       <= v1_q ? wrap1_q : '0;
            dout_valid_q <= v1_q;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign wrap       = wrap_q;

endmodule

// File: tb/tb_dds_wavegen.sv
// ---------------------------------------------------------------------------
// tb_dds_wavegen
// Self-checking bench for dds_wavegen (CHANNELS=2, PHASE_WIDTH=32,
// DATA_WIDTH=16). A behavioural model predicts dout/dout_valid/wrap/cfg_ready
// every cycle; directed scenarios add hand-computed literal expectations.
// Honours DDS_TRIANGLE_EN in the same way as the design.
// ---------------------------------------------------------------------------
module tb_dds_wavegen;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        phase_clr = 1'b0;
    logic [31:0] dout;
    logic        dout_valid;
    logic [1:0]  wrap;

    dds_wavegen_if #(.PHASE_WIDTH(32)) bus ();

    dds_wavegen #(
        .CHANNELS    (2),
        .PHASE_WIDTH (32),
        .DATA_WIDTH  (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg        (bus),
        .enable     (enable),
        .phase_clr  (phase_clr),
        .dout       (dout),
        .dout_valid (dout_valid),
        .wrap       (wrap)
    );

    always #2 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model -----------------------------------
    logic [31:0] m_acc [2];
    logic [31:0] m_act_freq [2], m_act_off [2];
    logic [1:0]  m_act_mode [2];
    logic [31:0] m_stg_freq [2], m_stg_off [2];
    logic [1:0]  m_stg_mode [2];
    bit          m_staged, m_apply, m_ready;
    // samples in flight: L1 made at the last edge, L2 the edge before
    logic [15:0] l1_s [2], l2_s [2];
    bit          l1_v, l2_v;
    logic [1:0]  l1_w, l2_w;
    logic [31:0] e_dout;
    bit          e_valid;
    logic [1:0]  e_wrap;

    function automatic logic [15:0] wave(input logic [31:0] p, input logic [1:0] mode,
                                         input logic [31:0] off);
        logic [31:0] x;
        case (mode)
            2'd1:    return (p >= 32'h8000_0000) ? 16'hFFFF : 16'h0000;
`ifdef DDS_TRIANGLE_EN
            2'd2: begin
                x = (p >> 15) & 32'h0000_FFFF;
                return (p >= 32'h8000_0000) ? 16'(32'h0000_FFFF - x) : 16'(x);
            end
`endif
            2'd3:    return 16'(off >> 16);
            default: return 16'(p >> 16);
        endcase
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            m_acc[c] = '0; m_act_freq[c] = '0; m_act_off[c] = '0; m_act_mode[c] = '0;
            m_stg_freq[c] = '0; m_stg_off[c] = '0; m_stg_mode[c] = '0;
            l1_s[c] = '0; l2_s[c] = '0;
        end
        m_staged = 0; m_apply = 0; m_ready = 1;
        l1_v = 0; l2_v = 0; l1_w = '0; l2_w = '0;
        e_dout = '0; e_valid = 0; e_wrap = '0;
    endtask

    task automatic model_step();
        bit          rdy_b, was_stg, wr;
        logic [32:0] s;
        logic [1:0]  carry;
        // outputs of this edge: the sample made two edges ago
        if (l2_v) e_dout = {l2_s[1], l2_s[0]};
        e_valid = l2_v;
        e_wrap  = l2_v ? l2_w : 2'b00;
        l2_s = l1_s; l2_v = l1_v; l2_w = l1_w;
        carry = '0;
        for (int c = 0; c < 2; c++) begin
            if (phase_clr) m_acc[c] = '0;
            else if (enable) begin
                s = {1'b0, m_acc[c]} + {1'b0, m_act_freq[c]};
                m_acc[c] = s[31:0];
                carry[c] = s[32];
            end
        end
        rdy_b = m_ready; was_stg = m_staged;
        if (m_apply) begin
            m_act_freq = m_stg_freq; m_act_off = m_stg_off; m_act_mode = m_stg_mode;
            m_apply = 0; m_ready = 1;
        end
        wr = bus.cfg_valid && rdy_b;
        if (wr) begin
            if (bus.cfg_chan < 4'd2) begin
                m_stg_freq[int'(bus.cfg_chan)] = bus.cfg_freq;
                m_stg_off[int'(bus.cfg_chan)]  = bus.cfg_offset;
                m_stg_mode[int'(bus.cfg_chan)] = bus.cfg_mode;
            end
            m_staged = 1;
        end
        if (rdy_b && bus.commit && was_stg) begin
            m_apply = 1; m_ready = 0; m_staged = 0;
        end
        for (int c = 0; c < 2; c++)
            l1_s[c] = wave(m_acc[c] + m_act_off[c], m_act_mode[c], m_act_off[c]);
        l1_v = enable;
        l1_w = carry;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else        model_step();
        end
    end

    // per-cycle compare against the model, away from the active edge
    initial begin
        forever begin
            @(negedge clk);
            if (chk_on) begin
                chk("dout",       dout,                 e_dout);
                chk("dout_valid", 32'(dout_valid),      32'(e_valid));
                chk("wrap",       32'(wrap),            32'(e_wrap));
                chk("cfg_ready",  32'(bus.cfg_ready),   32'(m_ready));
            end
        end
    end

    // ---------------- stimulus helpers ------------------------------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] ch, input logic [31:0] f, input logic [31:0] o,
                      input logic [1:0] m);
        bus.cfg_chan = ch; bus.cfg_freq = f; bus.cfg_offset = o; bus.cfg_mode = m;
        bus.cfg_valid = 1'b1;
        cyc();
        bus.cfg_valid = 1'b0;
    endtask

    task automatic do_commit();
        bus.commit = 1'b1;
        cyc();
        bus.commit = 1'b0;
    endtask

    task automatic do_reset();
        enable = 1'b0; phase_clr = 1'b0;
        bus.cfg_valid = 1'b0; bus.commit = 1'b0;
        rst_n = 1'b0;
        repeat (2) cyc();
        rst_n = 1'b1;
        cyc();
    endtask

    logic [31:0] d2, d3, d4;

    initial begin
        bus.cfg_chan = '0; bus.cfg_freq = '0; bus.cfg_offset = '0; bus.cfg_mode = '0;
        bus.cfg_valid = 1'b0; bus.commit = 1'b0;
        do_reset();
        chk_on = 1'b1;

        // reset state
        chk("rst_dout",  dout, 32'h0);
        chk("rst_valid", 32'(dout_valid), 32'h0);
        chk("rst_ready", 32'(bus.cfg_ready), 32'h1);
        chk("rst_wrap",  32'(wrap), 32'h0);

        // ramp: ch0 steps 0,1,2 starting two cycles after the enabled edge
        wr(4'd0, 32'h0001_0000, 32'h0, 2'd0);
        do_commit();
        enable = 1'b1;
        repeat (3) cyc();
        chk("ramp_s0", dout, 32'h0000_0000);
        chk("ramp_v0", 32'(dout_valid), 32'h1);
        cyc(); chk("ramp_s1", dout, 32'h0000_0001);
        cyc(); chk("ramp_s2", dout, 32'h0000_0002);
        repeat (20) cyc();

        // square, offset 0, with accumulator wrap on channel 1
        do_reset();
        wr(4'd1, 32'h4000_0000, 32'h0, 2'd1);
        do_commit();
        enable = 1'b1;
        repeat (3) cyc(); chk("sq_0", dout, 32'h0000_0000);
        cyc();            chk("sq_1", dout, 32'h0000_0000);
        cyc();            chk("sq_2", dout, 32'hFFFF_0000);
        cyc();            chk("sq_3", dout, 32'hFFFF_0000);
        cyc();            chk("sq_4", dout, 32'h0000_0000);
        chk("sq_wrap", 32'(wrap), 32'h2);
        repeat (10) cyc();

        // square with offset 0x4000_0000
        do_reset();
        wr(4'd1, 32'h4000_0000, 32'h4000_0000, 2'd1);
        do_commit();
        enable = 1'b1;
        repeat (3) cyc(); chk("sqo_0", dout, 32'h0000_0000);
        cyc();            chk("sqo_1", dout, 32'hFFFF_0000);
        cyc();            chk("sqo_2", dout, 32'hFFFF_0000);
        cyc();            chk("sqo_3", dout, 32'h0000_0000);

        // triangle (or ramp when the triangle is compiled out)
        do_reset();
        wr(4'd0, 32'h1000_0000, 32'h0, 2'd2);
        wr(4'd1, 32'h0, 32'hABCD_0000, 2'd3);
        do_commit();
        enable = 1'b1;
        repeat (3) cyc(); chk("tri_0", dout, 32'hABCD_0000);
        cyc();
`ifdef DDS_TRIANGLE_EN
        chk("tri_1", dout, 32'hABCD_2000);
`else
        chk("tri_1", dout, 32'hABCD_1000);
`endif
        repeat (7) cyc();
`ifdef DDS_TRIANGLE_EN
        chk("tri_8", dout, 32'hABCD_FFFF);
`else
        chk("tri_8", dout, 32'hABCD_8000);
`endif
        repeat (12) cyc();

        // atomic commit: staged writes invisible until commit
        do_reset();
        wr(4'd0, 32'h0001_0000, 32'h0, 2'd0);
        wr(4'd1, 32'h0002_0000, 32'h0, 2'd0);
        do_commit();
        enable = 1'b1;
        repeat (6) cyc();
        wr(4'd0, 32'h0003_0000, 32'h0, 2'd0);
        repeat (5) cyc();
        wr(4'd1, 32'h0005_0000, 32'h0, 2'd0);
        repeat (5) cyc();
        do_commit();
        chk("apply_ready0", 32'(bus.cfg_ready), 32'h0);
        cyc(); chk("apply_ready1", 32'(bus.cfg_ready), 32'h1);
        cyc(); d2 = dout;
        cyc(); d3 = dout;
        cyc(); d4 = dout;
        chk("slope_old_c0", 32'(d3[15:0] - d2[15:0]),   32'd1);
        chk("slope_new_c0", 32'(d4[15:0] - d3[15:0]),   32'd3);
        chk("slope_old_c1", 32'(d3[31:16] - d2[31:16]), 32'd2);
        chk("slope_new_c1", 32'(d4[31:16] - d3[31:16]), 32'd5);
        repeat (8) cyc();

        // boundaries: commit in IDLE, out-of-range channel, valid+commit
        do_reset();
        do_commit();
        chk("idle_commit_ready", 32'(bus.cfg_ready), 32'h1);
        wr(4'd5, 32'h0001_0000, 32'h0, 2'd0);
        do_commit();
        chk("chan5_apply", 32'(bus.cfg_ready), 32'h0);
        enable = 1'b1;
        repeat (6) cyc();
        chk("chan5_noeffect", dout, 32'h0);
        enable = 1'b0;
        wr(4'd0, 32'h0001_0000, 32'h0, 2'd0);
        bus.cfg_chan = 4'd1; bus.cfg_freq = 32'h0002_0000; bus.cfg_offset = '0;
        bus.cfg_mode = 2'd0; bus.cfg_valid = 1'b1; bus.commit = 1'b1;
        cyc();
        bus.cfg_valid = 1'b0; bus.commit = 1'b0;
        enable = 1'b1;
        repeat (4) cyc();
        chk("vc_include", dout, 32'h0002_0001);
        repeat (5) cyc();

        // phase_clr with enable: zero two cycles later
        phase_clr = 1'b1;
        cyc();
        phase_clr = 1'b0;
        repeat (2) cyc();
        chk("clr_dout", dout, 32'h0);
        repeat (5) cyc();

        // reset mid-run
        rst_n = 1'b0;
        #1;
        chk("midrst_dout",  dout, 32'h0);
        chk("midrst_valid", 32'(dout_valid), 32'h0);
        chk("midrst_ready", 32'(bus.cfg_ready), 32'h1);
        repeat (2) cyc();
        rst_n = 1'b1;
        repeat (5) cyc();
        chk("postrst_dout",  dout, 32'h0);
        chk("postrst_valid", 32'(dout_valid), 32'h1);
        repeat (3) cyc();

        chk_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
